// File: rtl/rtp_pkg.sv
// Shared constants, header field layout and state encodings for the RTP receive path.
package rtp_pkg;

    localparam int unsigned RTP_HDR_LEN = 12;
    localparam int unsigned UDP_HDR_LEN = 8;
    localparam logic [1:0]  RTP_VERSION = 2'b10;

    // Byte offsets of the header fields inside the RTP header
    localparam int unsigned PT_B    = 1;
    localparam int unsigned SEQ_HI  = 2;
    localparam int unsigned SEQ_LO  = 3;
    localparam int unsigned SSRC_B0 = 8;

    localparam int unsigned BYTE_W   = 8;
    localparam int unsigned SAMPLE_W = 16;
    localparam int unsigned CNT_W    = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HEADER,
        ST_PAYLOAD,
        ST_DISCARD
    } parse_state_t;

    typedef enum logic {
        MODE_BUFFERING,
        MODE_PLAYING
    } play_mode_t;

    // Header fields collected before the final SSRC byte arrives
    typedef struct packed {
        logic [1:0]  ver;
        logic [6:0]  pt;
        logic [15:0] seq;
        logic [23:0] ssrc_hi;
    } rtp_hdr_t;

endpackage

// File: rtl/audio_sync_fifo.sv
// Single-clock 16-bit sample FIFO with registered read data and a level counter.
module audio_sync_fifo #(
    parameter int unsigned AW = 11
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [15:0]   wr_data,
    input  logic          rd_en,
    input  logic          rd_clr,
    output logic [15:0]   rd_data,
    output logic [AW:0]   level,
    output logic          wr_drop_c
);

    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned LVL_W = AW + 1;

    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_ok_c;
    logic          rd_ok_c;

    // Full check looks only at the current level, a same-cycle read does not make room
    assign wr_ok_c   = wr_en && (level != LVL_W'(DEPTH));
    assign wr_drop_c = wr_en && !wr_ok_c;
    assign rd_ok_c   = rd_en && (level != '0);

    // Sample storage, no reset needed
    always_ff @(posedge clk) begin
        if (wr_ok_c) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers, level and the read data register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            rd_data <= '0;
        end else begin
            if (wr_ok_c) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_ok_c) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_ok_c, rd_ok_c})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
            if (rd_clr) begin
                rd_data <= '0;
            end else if (rd_ok_c) begin
                rd_data <= mem[rd_ptr];
            end
        end
    end

endmodule

// File: rtl/rtp_rx_depacketizer.sv
// RTP/L16 receive depacketizer: header filter, jitter FIFO and prefill-gated playback.
module rtp_rx_depacketizer #(
    parameter int unsigned FIFO_AW    = 11,
    parameter int unsigned PREFILL    = 960,
    parameter logic [6:0]  RTP_PT     = 7'd0,
    parameter logic [31:0] SSRC       = 32'h12345678,
    parameter int unsigned CHECK_SSRC = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               udp_rec_data_valid,
    input  logic [7:0]         udp_rec_rdata,
    input  logic [15:0]        udp_rec_data_length,
    input  logic               wav_rden,
    output logic [15:0]        wav_out_data,
    output logic [FIFO_AW:0]   fifo_level,
    output logic               playing,
    output logic [15:0]        pkt_ok_cnt,
    output logic [15:0]        pkt_drop_cnt,
    output logic [15:0]        seq_err_cnt,
    output logic [15:0]        underflow_cnt,
    output logic               overflow
);

    import rtp_pkg::*;

    localparam int unsigned LVL_W = FIFO_AW + 1;

    parse_state_t       state;
    play_mode_t         mode;
    rtp_hdr_t           hdr;
    logic [CNT_W-1:0]   byte_cnt;
    logic [CNT_W-1:0]   plen;
    logic [BYTE_W-1:0]  sample_hi;
    logic [15:0]        exp_seq;
    logic               seq_valid;

    logic [CNT_W-1:0]   plen_c;
    logic [CNT_W-1:0]   cnt_nxt_c;
    logic               last_c;
    logic               hdr_good_c;
    logic               fifo_wr_c;
    logic [SAMPLE_W-1:0] fifo_wdata_c;
    logic               fifo_rd_c;
    logic               fifo_clr_c;
    logic               wr_drop_c;

    // Datagram length is taken from the port on the first byte, from the latch afterwards
    assign plen_c    = (state == ST_IDLE) ? (udp_rec_data_length - CNT_W'(UDP_HDR_LEN)) : plen;
    assign cnt_nxt_c = byte_cnt + CNT_W'(1);
    assign last_c    = (cnt_nxt_c == plen_c);

    // Header verdict, evaluated while the last SSRC byte is on the bus
    assign hdr_good_c = (hdr.ver == RTP_VERSION) && (hdr.pt == RTP_PT) &&
                        ((CHECK_SSRC == 0) || ({hdr.ssrc_hi, udp_rec_rdata} == SSRC));

    // Payload bytes at odd header-relative offsets complete a big-endian sample
    assign fifo_wr_c    = udp_rec_data_valid && (state == ST_PAYLOAD) && byte_cnt[0];
    assign fifo_wdata_c = {sample_hi, udp_rec_rdata};

    // Playback requests pop only when playing with data; otherwise the output is zeroed
    assign fifo_rd_c  = wav_rden && (mode == MODE_PLAYING);
    assign fifo_clr_c = wav_rden && ((mode == MODE_BUFFERING) || (fifo_level == '0));
    assign playing    = (mode == MODE_PLAYING);

    // Parser FSM with header capture and datagram counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            hdr          <= '0;
            byte_cnt     <= '0;
            plen         <= '0;
            sample_hi    <= '0;
            exp_seq      <= '0;
            seq_valid    <= 1'b0;
            pkt_ok_cnt   <= '0;
            pkt_drop_cnt <= '0;
            seq_err_cnt  <= '0;
        end else if (udp_rec_data_valid) begin
            byte_cnt <= cnt_nxt_c;
            case (state)
                ST_IDLE: begin
                    plen     <= plen_c;
                    byte_cnt <= CNT_W'(1);
                    if (plen_c < CNT_W'(RTP_HDR_LEN)) begin
                        pkt_drop_cnt <= pkt_drop_cnt + 16'd1;
                        state        <= (plen_c <= CNT_W'(1)) ? ST_IDLE : ST_DISCARD;
                    end else begin
                        hdr.ver <= udp_rec_rdata[7:6];
                        state   <= ST_HEADER;
                    end
                end
                ST_HEADER: begin
                    if (byte_cnt == CNT_W'(PT_B)) begin
                        hdr.pt <= udp_rec_rdata[6:0];
                    end
                    if (byte_cnt == CNT_W'(SEQ_HI)) begin
                        hdr.seq[15:8] <= udp_rec_rdata;
                    end
                    if (byte_cnt == CNT_W'(SEQ_LO)) begin
                        hdr.seq[7:0] <= udp_rec_rdata;
                    end
                    if ((byte_cnt >= CNT_W'(SSRC_B0)) && (byte_cnt < CNT_W'(RTP_HDR_LEN - 1))) begin
                        hdr.ssrc_hi <= {hdr.ssrc_hi[15:0], udp_rec_rdata};
                    end
                    if (byte_cnt == CNT_W'(RTP_HDR_LEN - 1)) begin
                        if (hdr_good_c) begin
                            pkt_ok_cnt <= pkt_ok_cnt + 16'd1;
                            if (seq_valid && (hdr.seq != exp_seq)) begin
                                seq_err_cnt <= seq_err_cnt + 16'd1;
                            end
                            exp_seq   <= hdr.seq + 16'd1;
                            seq_valid <= 1'b1;
                            state     <= last_c ? ST_IDLE : ST_PAYLOAD;
                        end else begin
                            pkt_drop_cnt <= pkt_drop_cnt + 16'd1;
                            state        <= last_c ? ST_IDLE : ST_DISCARD;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (!byte_cnt[0]) begin
                        sample_hi <= udp_rec_rdata;
                    end
                    if (last_c) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    if (last_c) begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    // Playback mode, underflow counter and sticky overflow flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode          <= MODE_BUFFERING;
            underflow_cnt <= '0;
            overflow      <= 1'b0;
        end else begin
            if (wr_drop_c) begin
                overflow <= 1'b1;
            end
            case (mode)
                MODE_BUFFERING: begin
                    if (fifo_level >= LVL_W'(PREFILL)) begin
                        mode <= MODE_PLAYING;
                    end
                end
                default: begin
                    if (wav_rden && (fifo_level == '0)) begin
                        mode          <= MODE_BUFFERING;
                        underflow_cnt <= underflow_cnt + 16'd1;
                    end
                end
            endcase
        end
    end

    audio_sync_fifo #(
        .AW (FIFO_AW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (fifo_wr_c),
        .wr_data   (fifo_wdata_c),
        .rd_en     (fifo_rd_c),
        .rd_clr    (fifo_clr_c),
        .rd_data   (wav_out_data),
        .level     (fifo_level),
        .wr_drop_c (wr_drop_c)
    );

endmodule

// File: tb/tb_rtp_rx_depacketizer.sv
// Self-checking bench for rtp_rx_depacketizer: directed scenarios plus randomized datagrams.
module tb_rtp_rx_depacketizer;

    localparam int unsigned AW      = 11;
    localparam int unsigned DEPTH   = 1 << AW;
    localparam int unsigned PREFILL = 960;
    localparam logic [31:0] SSRC_OK = 32'h12345678;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid;
    logic [7:0]  rdata;
    logic [15:0] dlen;
    logic        rden;

    logic [15:0] wav_out_data;
    logic [AW:0] fifo_level;
    logic        playing;
    logic [15:0] pkt_ok_cnt, pkt_drop_cnt, seq_err_cnt, underflow_cnt;
    logic        overflow;

    logic [15:0] b_wav_out_data;
    logic [AW:0] b_fifo_level;
    logic        b_playing;
    logic [15:0] b_ok, b_drop, b_serr, b_under;
    logic        b_ovf;

    rtp_rx_depacketizer dut (
        .clk(clk), .rst_n(rst_n), .udp_rec_data_valid(valid), .udp_rec_rdata(rdata),
        .udp_rec_data_length(dlen), .wav_rden(rden), .wav_out_data(wav_out_data),
        .fifo_level(fifo_level), .playing(playing), .pkt_ok_cnt(pkt_ok_cnt),
        .pkt_drop_cnt(pkt_drop_cnt), .seq_err_cnt(seq_err_cnt),
        .underflow_cnt(underflow_cnt), .overflow(overflow)
    );

    rtp_rx_depacketizer #(.CHECK_SSRC(0)) dut_nossrc (
        .clk(clk), .rst_n(rst_n), .udp_rec_data_valid(valid), .udp_rec_rdata(rdata),
        .udp_rec_data_length(dlen), .wav_rden(1'b0), .wav_out_data(b_wav_out_data),
        .fifo_level(b_fifo_level), .playing(b_playing), .pkt_ok_cnt(b_ok),
        .pkt_drop_cnt(b_drop), .seq_err_cnt(b_serr),
        .underflow_cnt(b_under), .overflow(b_ovf)
    );

    always #10 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (datagram position arithmetic + sample queue)
    logic [15:0] mq[$];
    int          m_ok = 0, m_drop = 0, m_serr = 0, m_under = 0;
    int          m2_ok = 0, m2_drop = 0;
    bit          m_ovf = 0, m_play = 0, m_acc = 0, m_seq_valid = 0;
    logic [15:0] m_out = '0, m_exp_seq = '0;
    int          m_pos = 0, m_plen = 0;
    logic [7:0]  m_hdr [12];
    logic [7:0]  m_prev = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_ok = 0; m_drop = 0; m_serr = 0; m_under = 0; m2_ok = 0; m2_drop = 0;
            m_ovf = 0; m_play = 0; m_acc = 0; m_seq_valid = 0;
            m_out = '0; m_exp_seq = '0; m_pos = 0; m_plen = 0; m_prev = '0;
        end else begin
            int          lvl0;
            bit          play0, hdr_ok;
            logic [15:0] seq;
            logic [31:0] ssrc;
            lvl0  = mq.size();
            play0 = m_play;
            if (!play0 && lvl0 >= int'(PREFILL)) m_play = 1;
            if (rden) begin
                if (!play0) m_out = '0;
                else if (lvl0 > 0) m_out = mq.pop_front();
                else begin m_out = '0; m_under++; m_play = 0; end
            end
            if (valid) begin
                if (m_pos == 0) begin
                    m_plen = (int'(dlen) + 65536 - 8) % 65536;
                    m_acc  = 0;
                    if (m_plen < 12) begin m_drop++; m2_drop++; end
                end
                if (m_plen >= 12 && m_pos < 12) m_hdr[m_pos] = rdata;
                if (m_plen >= 12 && m_pos == 11) begin
                    seq    = {m_hdr[2], m_hdr[3]};
                    ssrc   = {m_hdr[8], m_hdr[9], m_hdr[10], m_hdr[11]};
                    hdr_ok = (m_hdr[0][7:6] == 2'd2) && (m_hdr[1][6:0] == 7'd0);
                    m_acc  = hdr_ok && (ssrc == SSRC_OK);
                    if (m_acc) begin
                        m_ok++;
                        if (m_seq_valid && seq != m_exp_seq) m_serr++;
                        m_exp_seq   = seq + 16'd1;
                        m_seq_valid = 1;
                    end else begin
                        m_drop++;
                    end
                    if (hdr_ok) m2_ok++; else m2_drop++;
                end
                if (m_pos >= 12 && m_acc && ((m_pos - 12) % 2 == 1)) begin
                    if (lvl0 == int'(DEPTH)) m_ovf = 1;
                    else mq.push_back({m_prev, rdata});
                end
                m_prev = rdata;
                m_pos++;
                if (m_pos >= m_plen) m_pos = 0;
            end
        end
    end

    // Cycle-by-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("wav_out_data", 32'(wav_out_data), 32'(m_out));
            check("fifo_level", 32'(fifo_level), 32'(mq.size()));
            check("playing", 32'(playing), 32'(m_play));
            check("pkt_ok_cnt", 32'(pkt_ok_cnt), 32'(16'(m_ok)));
            check("pkt_drop_cnt", 32'(pkt_drop_cnt), 32'(16'(m_drop)));
            check("seq_err_cnt", 32'(seq_err_cnt), 32'(16'(m_serr)));
            check("underflow_cnt", 32'(underflow_cnt), 32'(16'(m_under)));
            check("overflow", 32'(overflow), 32'(m_ovf));
            check("nossrc_ok_cnt", 32'(b_ok), 32'(16'(m2_ok)));
            check("nossrc_drop_cnt", 32'(b_drop), 32'(16'(m2_drop)));
        end
    end

    // ---------------- stimulus
    logic [7:0] pkt[$];
    bit         rden_rand = 0;

    task automatic cyc(input bit v, input logic [7:0] d, input bit r);
        @(negedge clk);
        valid = v;
        rdata = d;
        if (r) rden = 1'b1;
        else if (rden_rand && !rden && ($urandom_range(0, 99) < 80)) rden = 1'b1;
        else rden = 1'b0;
    endtask

    task automatic build(input logic [1:0] v, input logic [6:0] pt, input logic [15:0] seq,
                         input logic [31:0] ssrc, input int nsamp, input logic [15:0] first,
                         input bit odd);
        pkt.delete();
        pkt.push_back({v, 6'd0});
        pkt.push_back({1'b0, pt});
        pkt.push_back(seq[15:8]);
        pkt.push_back(seq[7:0]);
        for (int i = 0; i < 4; i++) pkt.push_back(8'(i + 8'h40));
        pkt.push_back(ssrc[31:24]);
        pkt.push_back(ssrc[23:16]);
        pkt.push_back(ssrc[15:8]);
        pkt.push_back(ssrc[7:0]);
        for (int i = 0; i < nsamp; i++) begin
            logic [15:0] s;
            s = first + 16'(i);
            pkt.push_back(s[15:8]);
            pkt.push_back(s[7:0]);
        end
        if (odd) pkt.push_back(8'hA5);
    endtask

    task automatic send(input int gap_pct);
        dlen = 16'(pkt.size() + 8);
        foreach (pkt[i]) begin
            while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) cyc(1'b0, 8'h00, 1'b0);
            cyc(1'b1, pkt[i], 1'b0);
        end
        cyc(1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        int          d0, l0, s0;
        logic [15:0] seq_n;
        logic [1:0]  v;
        logic [6:0]  pt;
        logic [31:0] ss;

        rst_n = 1'b0; valid = 1'b0; rdata = '0; dlen = '0; rden = 1'b0;
        #5;
        check("reset_level", 32'(fifo_level), 0);
        check("reset_ok_cnt", 32'(pkt_ok_cnt), 0);
        check("reset_playing", 32'(playing), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // 1: first valid datagram, 480 samples
        build(2'b10, 7'd0, 16'd0, SSRC_OK, 480, 16'h0001, 1'b0);
        send(0);
        check("t1_ok_cnt", 32'(pkt_ok_cnt), 1);
        check("t1_level", 32'(fifo_level), 480);
        check("t1_playing", 32'(playing), 0);

        // 2: second datagram reaches prefill, then drain in order
        build(2'b10, 7'd0, 16'd1, SSRC_OK, 480, 16'h01E1, 1'b0);
        send(0);
        check("t2_level_prefill", 32'(fifo_level), 960);
        check("t2_not_yet_playing", 32'(playing), 0);
        cyc(1'b0, 8'h00, 1'b0);
        check("t2_playing", 32'(playing), 1);
        for (int i = 0; i < 960; i++) begin
            cyc(1'b0, 8'h00, 1'b1);
            cyc(1'b0, 8'h00, 1'b0);
            if (i == 0) check("t2_first_sample", 32'(wav_out_data), 32'h0001);
        end
        check("t2_last_sample", 32'(wav_out_data), 32'h03C0);
        check("t2_level_empty", 32'(fifo_level), 0);

        // 3: underflow in PLAYING
        cyc(1'b0, 8'h00, 1'b1);
        cyc(1'b0, 8'h00, 1'b0);
        check("t3_underflow", 32'(underflow_cnt), 1);
        check("t3_playing", 32'(playing), 0);
        check("t3_out_zero", 32'(wav_out_data), 0);

        // 4: bad SSRC and bad version dropped; SSRC check disabled accepts the first
        d0 = int'(pkt_drop_cnt); l0 = int'(fifo_level); s0 = int'(b_ok);
        build(2'b10, 7'd0, 16'd2, 32'hDEADBEEF, 4, 16'h1000, 1'b0);
        send(0);
        build(2'b01, 7'd0, 16'd3, SSRC_OK, 4, 16'h1100, 1'b0);
        send(0);
        check("t4_drop_cnt", 32'(pkt_drop_cnt), 32'(d0 + 2));
        check("t4_level", 32'(fifo_level), 32'(l0));
        check("t4_nossrc_ok", 32'(b_ok), 32'(s0 + 1));

        // 5: sequence gaps, wrap, and an odd-length payload
        build(2'b10, 7'd0, 16'd5, SSRC_OK, 2, 16'h2000, 1'b0); send(0);
        s0 = int'(seq_err_cnt);
        build(2'b10, 7'd0, 16'd6, SSRC_OK, 2, 16'h2010, 1'b0); send(0);
        build(2'b10, 7'd0, 16'd9, SSRC_OK, 2, 16'h2020, 1'b0); send(0);
        check("t5_seq_gap", 32'(seq_err_cnt), 32'(s0 + 1));
        build(2'b10, 7'd0, 16'hFFFF, SSRC_OK, 2, 16'h2030, 1'b0); send(0);
        s0 = int'(seq_err_cnt);
        build(2'b10, 7'd0, 16'h0000, SSRC_OK, 2, 16'h2040, 1'b0); send(0);
        check("t5_seq_wrap", 32'(seq_err_cnt), 32'(s0));
        l0 = int'(fifo_level);
        build(2'b10, 7'd0, 16'h0001, SSRC_OK, 6, 16'h3000, 1'b1); send(0);
        check("t5_odd_payload", 32'(fifo_level), 32'(l0 + 6));

        // Randomized datagrams with concurrent playback requests
        rden_rand = 1;
        seq_n = 16'd2;
        for (int p = 0; p < 60; p++) begin
            int kind;
            kind = int'($urandom_range(0, 9));
            if (kind == 0) begin
                pkt.delete();
                for (int i = 0; i < int'($urandom_range(2, 11)); i++) pkt.push_back(8'($urandom));
            end else begin
                v  = (kind == 1) ? 2'($urandom_range(0, 1)) : 2'b10;
                pt = (kind == 2) ? 7'($urandom_range(1, 127)) : 7'd0;
                ss = (kind == 3) ? ($urandom | 32'h1) ^ SSRC_OK : SSRC_OK;
                if ($urandom_range(0, 4) == 0) seq_n = 16'($urandom);
                build(v, pt, seq_n, ss, int'($urandom_range(0, 300)), 16'($urandom),
                      1'($urandom_range(0, 1)));
                seq_n = seq_n + 16'd1;
            end
            send(20);
        end
        rden_rand = 0;
        repeat (3) cyc(1'b0, 8'h00, 1'b0);

        // 6: fill to full, then overflow
        while (mq.size() < DEPTH) begin
            int n;
            n = int'(DEPTH) - mq.size();
            if (n > 256) n = 256;
            build(2'b10, 7'd0, seq_n, SSRC_OK, n, 16'h4000, 1'b0);
            seq_n = seq_n + 16'd1;
            send(0);
        end
        check("t6_level_full", 32'(fifo_level), DEPTH);
        build(2'b10, 7'd0, seq_n, SSRC_OK, 4, 16'h5000, 1'b0);
        seq_n = seq_n + 16'd1;
        send(0);
        check("t6_level_stays", 32'(fifo_level), DEPTH);
        check("t6_overflow", 32'(overflow), 1);

        // Reset in the middle of a datagram
        build(2'b10, 7'd0, 16'd50, SSRC_OK, 20, 16'h6000, 1'b0);
        dlen = 16'(pkt.size() + 8);
        for (int i = 0; i < 15; i++) cyc(1'b1, pkt[i], 1'b0);
        #2;
        rst_n = 1'b0; valid = 1'b0; rden = 1'b0;
        #1;
        check("rst_wav_out", 32'(wav_out_data), 0);
        check("rst_level", 32'(fifo_level), 0);
        check("rst_playing", 32'(playing), 0);
        check("rst_ok_cnt", 32'(pkt_ok_cnt), 0);
        check("rst_drop_cnt", 32'(pkt_drop_cnt), 0);
        check("rst_seq_err", 32'(seq_err_cnt), 0);
        check("rst_underflow", 32'(underflow_cnt), 0);
        check("rst_overflow", 32'(overflow), 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        build(2'b10, 7'd0, 16'd100, SSRC_OK, 10, 16'h7000, 1'b0);
        send(0);
        check("post_rst_ok", 32'(pkt_ok_cnt), 1);
        check("post_rst_level", 32'(fifo_level), 10);
        check("post_rst_seq_err", 32'(seq_err_cnt), 0);
        repeat (2) cyc(1'b0, 8'h00, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rtp_rx_depacketizer.md
Name: rtp_rx_depacketizer

Overview:
Receive-side audio stage. It sits between the UDP receive byte stream of the Ethernet core and the codec playback interface (wav_out_data / wav_rden). It parses the 12-byte RTP header of each datagram and filters on version, payload type and SSRC. It writes big-endian 16-bit L16 samples into an internal single-clock jitter FIFO, and the playback side drains that FIFO once a prefill threshold is reached.

Parameters:
FIFO_AW, 11, FIFO address width; depth = 2^FIFO_AW samples (2048)
PREFILL, 960, sample count that must be buffered before playback starts or restarts
RTP_PT, 7'd0, accepted RTP payload type
SSRC, 32'h12345678, accepted SSRC
CHECK_SSRC, 1, 1 = drop datagrams whose SSRC differs; 0 = ignore the SSRC field

Ports:
clk  in  1  system clock (50 MHz); the only clock
rst_n  in  1  asynchronous active-low reset
udp_rec_data_valid  in  1  one UDP payload byte per high cycle
udp_rec_rdata  in  8  UDP payload byte, first byte = RTP byte 0
udp_rec_data_length  in  16  UDP length including 8-byte UDP header; stable for the whole datagram
wav_rden  in  1  playback sample request, single-cycle pulse
wav_out_data  out  16  playback sample, registered
fifo_level  out  FIFO_AW+1  current sample count
playing  out  1  1 = PLAYING mode
pkt_ok_cnt  out  16  accepted datagrams (wraps)
pkt_drop_cnt  out  16  datagrams rejected by header or length check (wraps)
seq_err_cnt  out  16  accepted datagrams whose sequence number != expected (wraps)
underflow_cnt  out  16  wav_rden pulses served while the FIFO was empty in PLAYING (wraps)
overflow  out  1  sticky; set when a sample is dropped because the FIFO is full; cleared only by reset

Behaviour:
- Reset (async assert, sync release): all outputs 0; parser in IDLE; FIFO empty; mode BUFFERING; seq_valid = 0.
- Parser FSM: IDLE, HEADER, PAYLOAD, DISCARD. byte_cnt counts valid bytes from 0. plen = udp_rec_data_length - 8, latched on the first byte.
- IDLE: on the first valid byte, latch plen and set byte_cnt = 1.
  - If plen < 12, go to DISCARD and increment pkt_drop_cnt.
  - Otherwise go to HEADER and capture byte 0.
- HEADER: capture bytes 0..11. Fields: V = byte0[7:6], PT = byte1[6:0], seq = bytes 2..3, SSRC = bytes 8..11.
  - After byte 11, the header is good if V == 2'b10, PT == RTP_PT, and (CHECK_SSRC == 0 or SSRC matches).
  - Good header: pkt_ok_cnt++. If seq_valid and seq != exp_seq, seq_err_cnt++. Then exp_seq = seq + 1 (16-bit wrap) and seq_valid = 1.
  - If plen == 12, go to IDLE; otherwise go to PAYLOAD.
  - Bad header: pkt_drop_cnt++. If byte_cnt == plen, go to IDLE; otherwise go to DISCARD.
- PAYLOAD: even-offset byte → high byte; the following byte completes the sample {hi, lo}, which is written to the FIFO.
  - An odd trailing byte is discarded.
  - Return to IDLE on the byte where byte_cnt == plen.
- DISCARD: consume bytes until byte_cnt == plen, then go to IDLE.
- The header and length decisions above also hold mid-datagram: the parser only leaves a datagram on its last byte.
- FIFO write: a write while fifo_level == 2^FIFO_AW is dropped and sets overflow. The full check ignores a same-cycle read.
  - A simultaneous accepted write and read leaves the level unchanged.
  - Pointers wrap modulo 2^FIFO_AW.
- Playback modes: BUFFERING and PLAYING.
  - BUFFERING: wav_rden causes no pop; wav_out_data <= 0. Move to PLAYING in the cycle after fifo_level >= PREFILL.
  - PLAYING: wav_rden with level > 0 pops, and wav_out_data is updated one clock after the wav_rden edge.
  - PLAYING: wav_rden with level == 0 sets wav_out_data <= 0, underflow_cnt++, and the mode returns to BUFFERING.
  - wav_out_data holds its value between requests.
- The parser runs independently of the playback mode; a write and a read may occur in the same cycle.

Decomposition:
- Shared package rtp_pkg holds:
  - RTP_HDR_LEN = 12, UDP_HDR_LEN = 8, RTP_VERSION = 2'b10
  - parser state encoding
  - header byte offsets (SEQ_HI = 2, SEQ_LO = 3, SSRC_B0 = 8)
- One sub-module, audio_sync_fifo: parameter AW, 16-bit, single clock, async active-low reset, registered read data, level output.
- The FSMs and counters stay in rtp_rx_depacketizer.

Test Plan:
1. Valid datagram, length 8+12+960 (plen = 972), PT 0, SSRC 0x12345678, samples 0x0001..0x01E0 → pkt_ok_cnt = 1, fifo_level = 480, playing = 0.
2. Send a second identical datagram with seq+1 → level reaches 960, playing = 1 next cycle. Then 960 wav_rden pulses → wav_out_data = 0x0001.. in order, each one clock after its pulse, and level = 0.
3. In PLAYING with level 0, pulse wav_rden → wav_out_data = 0, underflow_cnt = 1, playing = 0.
4. Datagram with SSRC 0xDEADBEEF, then one with V = 1 → pkt_drop_cnt = 2, fifo_level unchanged. Repeat the SSRC case with CHECK_SSRC = 0 → accepted.
5. Sequence numbers 5, 6, 9 → seq_err_cnt = 1. Sequence 0xFFFF then 0x0000 → no error. A 13-byte payload (plen = 25) → 6 samples written, last byte discarded.
6. Fill to 2048 samples, then send 4 more → level stays 2048, overflow = 1. Assert rst_n low mid-datagram → all outputs 0 immediately; the next datagram parses correctly.
